display_mux_scan: RTL
=====================

// Module: display_mux_scan
// PURPOSE
//  Time-multiplexed N-digit display selector: successor to the 2:1 4-bit digit mux.
//  Rotates through NUM_DIGITS packed DATA_W-bit values and drives one digit enable at a time.
//  Inserts a blanking interval between digits to remove ghosting, and skips masked-off digits.
//  Snapshots all inputs once per frame so every digit in a frame is coherent.
//  Sits between keypad/digit registers and the seven-segment decoder + anode drivers.
// PARAMETERS
//  NUM_DIGITS      2      number of multiplexed digits (>=2)
//  DATA_W          4      bits per digit value
//  REFRESH_CYCLES  24000  clk cycles each digit is shown (>=2)
//  BLANK_CYCLES    240    clk cycles all enables are off between digits (>=1)
//  EN_ACTIVE_LOW   1      1: digit_en active-low (PNP anode drive); 0: active-high
// PORTS
//  clk         in   1                   system clock
//  reset       in   1                   asynchronous, active-high reset
//  d_in        in   NUM_DIGITS*DATA_W   packed digit values; digit i = d_in[i*DATA_W +: DATA_W]
//  en_mask     in   NUM_DIGITS          1 = digit participates in scan
//  y           out  DATA_W              value of currently shown digit (to segment decoder)
//  digit_en    out  NUM_DIGITS          one-hot (polarity per EN_ACTIVE_LOW) anode enables
//  digit_idx   out  $clog2(NUM_DIGITS)  index of current/last shown digit
//  frame_start out  1                   1-cycle pulse on the first SHOW cycle of each frame
// BEHAVIOUR
//  - Reset (async assert, sync-release use): state=BLANK, cnt=0, digit_idx=0, y=0,
//    snapshot=0, frame_start=0, digit_en all inactive. Nothing updates while reset=1.
//  - FSM states: BLANK, SHOW. cnt counts 0..len-1 in each state; transition when cnt==len-1,
//    cnt returns to 0. len = BLANK_CYCLES in BLANK, REFRESH_CYCLES in SHOW.
//  - BLANK end: next = first set bit of en_mask cyclically after digit_idx (inclusive of
//    digit_idx itself only if it is the sole set bit); first BLANK after reset searches from 0
//    inclusive. If en_mask==0: stay BLANK, restart cnt, digit_idx unchanged.
//  - Entering SHOW: digit_idx<=next. If next<=old digit_idx, or first SHOW after reset, this is
//    a frame start: snapshot<=d_in, frame_start=1 for that first SHOW cycle.
//  - SHOW: digit_en[digit_idx] active, all others inactive; y=snapshot[digit_idx], registered.
//  - BLANK: all digit_en inactive; y and digit_idx hold last value (no glitch to decoder).
//  - All outputs registered; digit_en is never active for two digits in the same cycle.
//  - en_mask sampled only at BLANK end; mid-SHOW mask changes do not cut the current digit.
//  - d_in changes mid-frame are not visible until the next frame_start.
//  - Reset mid-SHOW: enables drop inactive immediately (async); scan restarts from BLANK.
//  - Single enabled digit: that digit repeats SHOW/BLANK; frame_start every SHOW.
// STRUCTURE
//  - display_pkg: scan_state_t enum {BLANK, SHOW}; helper function next_enabled(mask, idx).
//  - Sub-module refresh_timer (parametrised terminal-count counter, clear input, tc output)
//    sized to max(REFRESH_CYCLES, BLANK_CYCLES).
//  - Top holds FSM, index register, snapshot register, output registers, polarity inversion.
// TESTING (NUM_DIGITS=3, DATA_W=4, REFRESH_CYCLES=4, BLANK_CYCLES=2, EN_ACTIVE_LOW=1)
//  1 Reset release at cycle 0, en_mask=3'b111, d_in={4'hC,4'hB,4'hA} -> cycles 0-1 digit_en=111;
//    2-5 digit_en=110,y=A,frame_start@2; 8-11 101,y=B; 14-17 011,y=C; 20 110,y=A,frame_start.
//  2 en_mask=3'b101 -> sequence digit0,digit2,digit0; digit1 never enabled; period 12 cycles.
//  3 Change d_in digit0 to 4'h5 during digit1 SHOW -> y stays A for digit0 until next frame,
//    then 5 from the following frame_start.
//  4 en_mask=0 from reset -> digit_en stays 111, y=0, frame_start never pulses; set 3'b010 ->
//    digit1 shown within BLANK_CYCLES+1 cycles, frame_start pulses each SHOW.
//  5 Assert reset mid-SHOW of digit1 -> digit_en=111 and y=0 in same cycle (async); after
//    release scan restarts at digit0 after 2 blank cycles.
//  6 Assertion throughout: $onehot0(~digit_en) every cycle; no SHOW without blank gap >=2.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed digit scanner.
package display_pkg;

    // Largest digit count the index search helper supports.
    localparam int MAX_DIGITS = 16;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Returns the first set bit of mask cyclically after idx. idx itself is
    // reached only after every other digit has been tried, so it is returned
    // only when it is the sole set bit. Returns idx when mask is empty.
    function automatic int next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                        input int n,
                                        input int idx);
        int r;
        int j;
        logic [MAX_DIGITS-1:0] sh;
        r = idx;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = MAX_DIGITS; k >= 1; k--) begin
            if (k <= n) begin
                j = idx + k;
                if (j >= n) j = j - n;
                sh = mask >> j;
                if (sh[0]) r = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Terminal-count counter: counts 0..i_last, wraps on tc, clears on demand.
module refresh_timer #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = (r_cnt == i_last);

    // Free-running count that restarts at the terminal value or on clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_mux_scan.sv
// Time-multiplexed N-digit display selector with blanking, digit masking and
// per-frame input snapshot. All outputs come straight from registers.
module display_mux_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int DATA_W         = 4,
    parameter int REFRESH_CYCLES = 24000,
    parameter int BLANK_CYCLES   = 240,
    parameter bit EN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DIGITS*DATA_W-1:0] d_in,
    input  logic [NUM_DIGITS-1:0]        en_mask,
    output logic [DATA_W-1:0]            y,
    output logic [NUM_DIGITS-1:0]        digit_en,
    output logic [IDX_W-1:0]             digit_idx,
    output logic                         frame_start
);

    localparam int MAX_LEN = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] EN_OFF     = EN_ACTIVE_LOW ? '1 : '0;

    scan_state_t         r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_first;
    logic [DATA_W-1:0]   r_snap [NUM_DIGITS];
    logic [DATA_W-1:0]   r_y;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                r_frame_start;

    logic [DATA_W-1:0]     w_din [NUM_DIGITS];
    logic [IDX_W-1:0]      w_next;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_tc;
    logic                  w_frame;
    logic [CNT_W-1:0]      w_last;

    // Unpacked view of the packed digit bus.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_din
        assign w_din[g] = d_in[g*DATA_W +: DATA_W];
    end

    assign w_last = (r_state == SHOW) ? SHOW_LAST : BLANK_LAST;

    refresh_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_last  (w_last),
        .o_tc    (w_tc)
    );

    // After reset the search starts from the last index so digit 0 is tried first.
    assign w_next  = IDX_W'(next_enabled(MAX_DIGITS'(en_mask), NUM_DIGITS,
                                         r_first ? NUM_DIGITS - 1 : int'(r_idx)));
    // Wrapping back to an equal or lower index means a new frame begins.
    assign w_frame = r_first || (w_next <= r_idx);

    // Decode the chosen digit to a one-hot enable pattern.
    always_comb begin
        w_onehot         = '0;
        w_onehot[w_next] = 1'b1;
    end

    // Scan FSM: alternate BLANK/SHOW, pick the next enabled digit at BLANK end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_first       <= 1'b1;
            r_y           <= '0;
            r_digit_en    <= EN_OFF;
            r_frame_start <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= '0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tc) begin
                if (r_state == SHOW) begin
                    // y and index hold through blanking so the decoder sees no glitch.
                    r_state    <= BLANK;
                    r_digit_en <= EN_OFF;
                end else if (|en_mask) begin
                    r_state    <= SHOW;
                    r_idx      <= w_next;
                    r_first    <= 1'b0;
                    r_digit_en <= w_onehot ^ EN_OFF;
                    if (w_frame) begin
                        for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_din[i];
                        r_y           <= w_din[w_next];
                        r_frame_start <= 1'b1;
                    end else begin
                        r_y <= r_snap[w_next];
                    end
                end
                // Empty mask: stay in BLANK, timer has already wrapped.
            end
        end
    end

    assign y           = r_y;
    assign digit_en    = r_digit_en;
    assign digit_idx   = r_idx;
    assign frame_start = r_frame_start;

endmodule
